// File: rtl/lut_wvf_loader.sv
// lut_wvf_loader: streams quarter-wave samples into a shadow bank and
// commits them to the active bank that drives the generator's LUT_ROM bus.
// A commit happens only while the generator is idle or stepping out of its
// final entry, so a running waveform never sees a half-updated table.
module lut_wvf_loader #(
  parameter int LUT_WIDTH = 32,
  parameter int BIT_WIDTH = 16
) (
  input  logic                                 CLK_SYS,
  input  logic                                 RST,
  input  logic                                 START,
  input  logic [BIT_WIDTH-2:0]                 DATA_IN,
  input  logic                                 DATA_VALID,
  output logic                                 DATA_READY,
  input  logic                                 GEN_ACTIVE,
  input  logic                                 LUT_STEP,
  input  logic                                 LUT_END_IN,
  output logic [(BIT_WIDTH-1)*LUT_WIDTH-1:0]   LUT_ROM,
  output logic                                 LUT_VALID,
  output logic                                 BUSY,
  output logic                                 SWAP_DONE
);

  localparam int ENTRY_W = BIT_WIDTH - 1;
  localparam int PTR_W   = $clog2(LUT_WIDTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(LUT_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t                          state;
  state_t                          state_next;
  logic [PTR_W-1:0]                wr_ptr;
  logic [ENTRY_W-1:0]              shadow [LUT_WIDTH];
  logic [ENTRY_W*LUT_WIDTH-1:0]    active_bank;
  logic                            lut_valid_q;
  logic                            swap_done_q;
  logic                            beat_accept;
  logic                            last_beat;
  logic                            commit;

  // A restart always wins over a pending commit, so START gates the commit.
  assign beat_accept = DATA_VALID && DATA_READY;
  assign last_beat   = (wr_ptr == LAST_IDX);
  assign commit      = (state == ARMED) && !START &&
                       (!GEN_ACTIVE || (LUT_STEP && LUT_END_IN));

  // State register.
  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: START (re)enters LOAD from any state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (START) state_next = LOAD;
      end
      LOAD: begin
        if (START)                         state_next = LOAD;
        else if (beat_accept && last_beat) state_next = ARMED;
      end
      ARMED: begin
        if (START)       state_next = LOAD;
        else if (commit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    DATA_READY = (state == LOAD) && !START;
    BUSY       = (state != IDLE);
  end

  // Write pointer: cleared by START, advanced per accepted beat, wraps on the last.
  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      wr_ptr <= '0;
    end else if (START) begin
      wr_ptr <= '0;
    end else if (beat_accept) begin
      wr_ptr <= last_beat ? '0 : wr_ptr + PTR_W'(1);
    end
  end

  // Shadow bank capture; entries keep their contents until rewritten.
  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      for (int i = 0; i < LUT_WIDTH; i++) begin
        shadow[i] <= '0;
      end
    end else if (beat_accept) begin
      shadow[wr_ptr] <= DATA_IN;
    end
  end

  // Active bank, valid flag and swap pulse change only on commit or reset.
  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      active_bank <= '0;
      lut_valid_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      swap_done_q <= commit;
      if (commit) begin
        for (int i = 0; i < LUT_WIDTH; i++) begin
          active_bank[i*ENTRY_W +: ENTRY_W] <= shadow[i];
        end
        lut_valid_q <= 1'b1;
      end
    end
  end

  assign LUT_ROM   = active_bank;
  assign LUT_VALID = lut_valid_q;
  assign SWAP_DONE = swap_done_q;

endmodule

// File: tb/tb_lut_wvf_loader.sv
// tb_lut_wvf_loader: directed scenarios for the LUT loader, one instance with
// four entries and one with five, 7-bit entries in both.
module tb_lut_wvf_loader;

  logic        CLK_SYS = 1'b0;

  logic        RST, START, DATA_VALID, GEN_ACTIVE, LUT_STEP, LUT_END_IN;
  logic [6:0]  DATA_IN;
  logic        DATA_READY, LUT_VALID, BUSY, SWAP_DONE;
  logic [27:0] LUT_ROM;

  logic        RST5, START5, DATA_VALID5, GEN_ACTIVE5, LUT_STEP5, LUT_END_IN5;
  logic [6:0]  DATA_IN5;
  logic        DATA_READY5, LUT_VALID5, BUSY5, SWAP_DONE5;
  logic [34:0] LUT_ROM5;

  int passed = 0;
  int total  = 0;

  lut_wvf_loader #(.LUT_WIDTH(4), .BIT_WIDTH(8)) dut (
    .CLK_SYS(CLK_SYS), .RST(RST), .START(START), .DATA_IN(DATA_IN),
    .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .GEN_ACTIVE(GEN_ACTIVE),
    .LUT_STEP(LUT_STEP), .LUT_END_IN(LUT_END_IN), .LUT_ROM(LUT_ROM),
    .LUT_VALID(LUT_VALID), .BUSY(BUSY), .SWAP_DONE(SWAP_DONE)
  );

  lut_wvf_loader #(.LUT_WIDTH(5), .BIT_WIDTH(8)) dut5 (
    .CLK_SYS(CLK_SYS), .RST(RST5), .START(START5), .DATA_IN(DATA_IN5),
    .DATA_VALID(DATA_VALID5), .DATA_READY(DATA_READY5), .GEN_ACTIVE(GEN_ACTIVE5),
    .LUT_STEP(LUT_STEP5), .LUT_END_IN(LUT_END_IN5), .LUT_ROM(LUT_ROM5),
    .LUT_VALID(LUT_VALID5), .BUSY(BUSY5), .SWAP_DONE(SWAP_DONE5)
  );

  // 10-unit system clock.
  always #5 CLK_SYS = ~CLK_SYS;

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge CLK_SYS);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    cycle();
    START = 1'b0;
  endtask

  // Feed four consecutive beats with DATA_VALID held high.
  task automatic feed4(input logic [6:0] b0, input logic [6:0] b1,
                       input logic [6:0] b2, input logic [6:0] b3);
    logic [6:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int i = 0; i < 4; i++) begin
      DATA_VALID = 1'b1;
      DATA_IN    = b[i];
      cycle();
    end
    DATA_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; RST5 = 1'b1;
    cycle();
    cycle();
    RST = 1'b0; RST5 = 1'b0;
    DATA_VALID = 1'b1;
    #1;
    total++; if (LUT_ROM !== 28'h0) $display("[TB] FAIL reset_rom: got %h expected 0", LUT_ROM); else passed++;
    total++; if (LUT_VALID !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", LUT_VALID); else passed++;
    total++; if (BUSY !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); else passed++;
    total++; if (DATA_READY !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", DATA_READY); else passed++;
    total++; if (SWAP_DONE !== 1'b0) $display("[TB] FAIL reset_swap: got %b expected 0", SWAP_DONE); else passed++;
    total++; if (LUT_ROM5 !== 35'h0) $display("[TB] FAIL reset_rom5: got %h expected 0", LUT_ROM5); else passed++;
    cycle();
    total++; if (BUSY !== 1'b0) $display("[TB] FAIL idle_ignores_valid: busy got %b expected 0", BUSY); else passed++;
    DATA_VALID = 1'b0;
  endtask

  task automatic test_basic_load();
    logic [6:0] b [4];
    int ready_cnt;
    b[0] = 7'h10; b[1] = 7'h20; b[2] = 7'h30; b[3] = 7'h7F;
    ready_cnt = 0;
    GEN_ACTIVE = 1'b0;
    pulse_start();
    total++; if (BUSY !== 1'b1) $display("[TB] FAIL load_busy: got %b expected 1", BUSY); else passed++;
    for (int i = 0; i < 4; i++) begin
      DATA_VALID = 1'b1;
      DATA_IN    = b[i];
      #1;
      if (DATA_READY === 1'b1) ready_cnt++;
      cycle();
    end
    total++; if (ready_cnt !== 4) $display("[TB] FAIL ready_beats: got %0d expected 4", ready_cnt); else passed++;
    DATA_IN = 7'h55;
    #1;
    total++; if (DATA_READY !== 1'b0) $display("[TB] FAIL ready_after_last: got %b expected 0", DATA_READY); else passed++;
    total++; if (BUSY !== 1'b1) $display("[TB] FAIL armed_busy: got %b expected 1", BUSY); else passed++;
    total++; if (LUT_ROM !== 28'h0) $display("[TB] FAIL rom_before_commit: got %h expected 0", LUT_ROM); else passed++;
    cycle();
    total++; if (LUT_ROM !== {7'h7F, 7'h30, 7'h20, 7'h10}) $display("[TB] FAIL basic_rom: got %h expected %h", LUT_ROM, {7'h7F, 7'h30, 7'h20, 7'h10}); else passed++;
    total++; if (SWAP_DONE !== 1'b1) $display("[TB] FAIL basic_swap: got %b expected 1", SWAP_DONE); else passed++;
    total++; if (LUT_VALID !== 1'b1) $display("[TB] FAIL basic_valid: got %b expected 1", LUT_VALID); else passed++;
    total++; if (BUSY !== 1'b0) $display("[TB] FAIL basic_idle: got %b expected 0", BUSY); else passed++;
    cycle();
    total++; if (SWAP_DONE !== 1'b0) $display("[TB] FAIL swap_single: got %b expected 0", SWAP_DONE); else passed++;
    DATA_VALID = 1'b0;
  endtask

  task automatic test_gated_commit();
    logic [27:0] old_rom;
    old_rom = {7'h7F, 7'h30, 7'h20, 7'h10};
    GEN_ACTIVE = 1'b1;
    pulse_start();
    feed4(7'h01, 7'h02, 7'h03, 7'h04);
    LUT_STEP = 1'b1; LUT_END_IN = 1'b0;
    cycle();
    total++; if (LUT_ROM !== old_rom) $display("[TB] FAIL step_no_end: got %h expected %h", LUT_ROM, old_rom); else passed++;
    total++; if (BUSY !== 1'b1) $display("[TB] FAIL still_armed: got %b expected 1", BUSY); else passed++;
    LUT_STEP = 1'b0; LUT_END_IN = 1'b1;
    cycle();
    total++; if (LUT_ROM !== old_rom) $display("[TB] FAIL end_no_step: got %h expected %h", LUT_ROM, old_rom); else passed++;
    LUT_STEP = 1'b1; LUT_END_IN = 1'b1;
    cycle();
    LUT_STEP = 1'b0; LUT_END_IN = 1'b0;
    total++; if (LUT_ROM !== {7'h04, 7'h03, 7'h02, 7'h01}) $display("[TB] FAIL wrap_commit: got %h expected %h", LUT_ROM, {7'h04, 7'h03, 7'h02, 7'h01}); else passed++;
    total++; if (SWAP_DONE !== 1'b1) $display("[TB] FAIL wrap_swap: got %b expected 1", SWAP_DONE); else passed++;
    cycle();
  endtask

  task automatic test_restart_mid_load();
    GEN_ACTIVE = 1'b0;
    pulse_start();
    DATA_VALID = 1'b1;
    DATA_IN = 7'h11; cycle();
    DATA_IN = 7'h12; cycle();
    START = 1'b1; DATA_IN = 7'h13;
    #1;
    total++; if (DATA_READY !== 1'b0) $display("[TB] FAIL restart_ready: got %b expected 0", DATA_READY); else passed++;
    cycle();
    START = 1'b0;
    feed4(7'h21, 7'h22, 7'h23, 7'h24);
    cycle();
    total++; if (LUT_ROM !== {7'h24, 7'h23, 7'h22, 7'h21}) $display("[TB] FAIL restart_rom: got %h expected %h", LUT_ROM, {7'h24, 7'h23, 7'h22, 7'h21}); else passed++;
    cycle();
  endtask

  task automatic test_start_vs_commit();
    logic [27:0] old_rom;
    old_rom = {7'h24, 7'h23, 7'h22, 7'h21};
    GEN_ACTIVE = 1'b1;
    pulse_start();
    feed4(7'h31, 7'h32, 7'h33, 7'h34);
    START = 1'b1; GEN_ACTIVE = 1'b0;
    cycle();
    START = 1'b0;
    #1;
    total++; if (SWAP_DONE !== 1'b0) $display("[TB] FAIL race_swap: got %b expected 0", SWAP_DONE); else passed++;
    total++; if (LUT_ROM !== old_rom) $display("[TB] FAIL race_rom: got %h expected %h", LUT_ROM, old_rom); else passed++;
    total++; if (DATA_READY !== 1'b1) $display("[TB] FAIL race_load: got %b expected 1", DATA_READY); else passed++;
    feed4(7'h41, 7'h42, 7'h43, 7'h44);
    cycle();
    total++; if (LUT_ROM !== {7'h44, 7'h43, 7'h42, 7'h41}) $display("[TB] FAIL race_reload: got %h expected %h", LUT_ROM, {7'h44, 7'h43, 7'h42, 7'h41}); else passed++;
    cycle();
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    DATA_VALID = 1'b1;
    DATA_IN = 7'h61; cycle();
    DATA_IN = 7'h62; cycle();
    DATA_IN = 7'h63; cycle();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    #1;
    total++; if (LUT_ROM !== 28'h0) $display("[TB] FAIL rst_rom: got %h expected 0", LUT_ROM); else passed++;
    total++; if (LUT_VALID !== 1'b0) $display("[TB] FAIL rst_valid: got %b expected 0", LUT_VALID); else passed++;
    total++; if (BUSY !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", BUSY); else passed++;
    total++; if (DATA_READY !== 1'b0) $display("[TB] FAIL rst_ready: got %b expected 0", DATA_READY); else passed++;
    cycle();
    cycle();
    total++; if (BUSY !== 1'b0) $display("[TB] FAIL rst_ignore_valid: got %b expected 0", BUSY); else passed++;
    DATA_VALID = 1'b0;
  endtask

  task automatic test_gaps();
    logic [6:0] b [4];
    int k;
    int acc;
    b[0] = 7'h4A; b[1] = 7'h3B; b[2] = 7'h2C; b[3] = 7'h1D;
    k = 0; acc = 0;
    GEN_ACTIVE = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      DATA_VALID = (i % 2 == 0);
      DATA_IN    = DATA_VALID ? b[k] : 7'h5A;
      #1;
      if (DATA_VALID && DATA_READY) begin
        acc++;
        k++;
      end
      cycle();
    end
    DATA_VALID = 1'b0;
    total++; if (acc !== 4) $display("[TB] FAIL gap_beats: got %0d expected 4", acc); else passed++;
    total++; if (LUT_ROM !== {7'h1D, 7'h2C, 7'h3B, 7'h4A}) $display("[TB] FAIL gap_rom: got %h expected %h", LUT_ROM, {7'h1D, 7'h2C, 7'h3B, 7'h4A}); else passed++;
    total++; if (SWAP_DONE !== 1'b1) $display("[TB] FAIL gap_swap: got %b expected 1", SWAP_DONE); else passed++;
    cycle();
  endtask

  task automatic test_gaps_w5();
    logic [6:0] b [5];
    int k;
    b[0] = 7'h05; b[1] = 7'h15; b[2] = 7'h25; b[3] = 7'h35; b[4] = 7'h6E;
    k = 0;
    GEN_ACTIVE5 = 1'b0;
    START5 = 1'b1;
    cycle();
    START5 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      DATA_VALID5 = (i % 2 == 0);
      DATA_IN5    = DATA_VALID5 ? b[k] : 7'h2A;
      #1;
      if (DATA_VALID5 && DATA_READY5) k++;
      cycle();
    end
    DATA_VALID5 = 1'b0;
    total++; if (k !== 5) $display("[TB] FAIL w5_beats: got %0d expected 5", k); else passed++;
    total++; if (LUT_ROM5[34:28] !== 7'h6E) $display("[TB] FAIL w5_entry4: got %h expected 6e", LUT_ROM5[34:28]); else passed++;
    total++; if (LUT_ROM5 !== {7'h6E, 7'h35, 7'h25, 7'h15, 7'h05}) $display("[TB] FAIL w5_rom: got %h expected %h", LUT_ROM5, {7'h6E, 7'h35, 7'h25, 7'h15, 7'h05}); else passed++;
    total++; if (LUT_VALID5 !== 1'b1) $display("[TB] FAIL w5_valid: got %b expected 1", LUT_VALID5); else passed++;
  endtask

  // Scenario sequence; every wait is a fixed cycle count so the run always ends.
  initial begin
    RST = 1'b1; START = 1'b0; DATA_IN = '0; DATA_VALID = 1'b0;
    GEN_ACTIVE = 1'b0; LUT_STEP = 1'b0; LUT_END_IN = 1'b0;
    RST5 = 1'b1; START5 = 1'b0; DATA_IN5 = '0; DATA_VALID5 = 1'b0;
    GEN_ACTIVE5 = 1'b0; LUT_STEP5 = 1'b0; LUT_END_IN5 = 1'b0;
    test_reset();
    test_basic_load();
    test_gated_commit();
    test_restart_mid_load();
    test_start_vs_commit();
    test_reset_mid_load();
    test_gaps();
    test_gaps_w5();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
